fetch_queue_unit: RTL and testbench

Parametrised successor to the single-entry front fetch stage. It owns the fetch PC and issues in-order instruction-memory requests. Up to DEPTH requests may be in flight, and returned words are buffered in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake. A jump redirects the PC, flushes the FIFO and discards the responses of requests issued before the jump.

---
 rtl/fetch_queue_unit.sv | 209 ++++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the fetch PC and issues in-order instruction-memory
// requests. Up to DEPTH requests may be in flight. Returned words are buffered
// in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake.
// A jump redirects the PC, empties the FIFO and discards the responses of
// requests that were issued before the jump.
// Optional feature macro: FETCH_ADDR_TRACE_EN adds inst_addr_o, which carries
// the fetch address of the head instruction.

module fetch_queue_unit_chk #(
  parameter int unsigned CW = 3
) (
  input logic          i_clk,
  input logic          i_reset_n,
  input logic          i_rvalid,
  input logic [CW-1:0] i_outstanding
);
  // A response must never arrive when no request is outstanding.
  a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    i_rvalid |-> (i_outstanding != CW'(0)));
endmodule

module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o
`ifdef FETCH_ADDR_TRACE_EN
  ,
  output logic [XLEN-1:0] inst_addr_o
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_inst;

  logic [CW:0]     w_occupancy;
  logic            w_credit;
  logic            w_issue;
  logic            w_rsp;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_dec;
  logic [CW-1:0]   w_out_nxt;
  logic [CW-1:0]   w_disc_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [AW-1:0]   w_rd_nxt;
  logic            w_head_load;
  logic [XLEN-1:0] w_head_data;

  // Credit: in-flight requests plus buffered words may never exceed DEPTH,
  // so every response is guaranteed a FIFO slot. Requests are held off while
  // reset is asserted.
  assign w_occupancy  = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_credit     = (w_occupancy < (CW + 1)'(DEPTH));
  assign mem_req_o    = reset_n & w_credit & ~jump_flag_i;
  assign mem_addr_o   = r_pc;
  assign w_issue      = mem_req_o & mem_gnt_i;
  // Responses with nothing outstanding are ignored.
  assign w_rsp        = mem_rvalid_i & (r_outstanding != CW'(0));
  assign w_push       = w_rsp & ~jump_flag_i & (r_discard == CW'(0));
  assign inst_valid_o = (r_count != CW'(0));
  assign w_pop        = inst_valid_o & inst_ready_i;
  assign inst_o       = r_inst;

  // Next-state for counters and read pointer, plus the word that becomes the head.
  always_comb begin
    w_out_dec   = r_outstanding - CW'(w_rsp);
    w_out_nxt   = w_out_dec;
    w_disc_nxt  = r_discard;
    w_count_nxt = r_count;
    w_rd_nxt    = r_rd_ptr;
    if (jump_flag_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      w_out_nxt   = w_out_dec;
      w_disc_nxt  = w_out_dec;
      w_count_nxt = CW'(0);
      w_rd_nxt    = r_wr_ptr;
    end else begin
      w_out_nxt = w_out_dec + CW'(w_issue);
      if (w_rsp && (r_discard != CW'(0))) begin
        w_disc_nxt = r_discard - CW'(1);
      end else begin
        w_disc_nxt = r_discard;
      end
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_rd_nxt    = r_rd_ptr + AW'(w_pop);
    end
    w_head_load = ~jump_flag_i & (w_count_nxt != CW'(0));
    // The new head is the incoming word when the FIFO was empty after the pop.
    if (w_push && (w_rd_nxt == r_wr_ptr)) begin
      w_head_data = mem_rdata_i;
    end else begin
      w_head_data = r_mem[w_rd_nxt];
    end
  end

  // FIFO data storage; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= mem_rdata_i;
    end
  end

  // PC, credit counters, FIFO pointers and the registered head word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_outstanding <= CW'(0);
      r_discard     <= CW'(0);
      r_count       <= CW'(0);
      r_wr_ptr      <= AW'(0);
      r_rd_ptr      <= AW'(0);
      r_inst        <= XLEN'(0);
    end else begin
      if (jump_flag_i) begin
        r_pc <= jump_addr_i;
      end else if (w_issue) begin
        r_pc <= r_pc + XLEN'(PC_STEP);
      end
      r_outstanding <= w_out_nxt;
      r_discard     <= w_disc_nxt;
      r_count       <= w_count_nxt;
      r_rd_ptr      <= w_rd_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_head_load) begin
        r_inst <= w_head_data;
      end
    end
  end

`ifdef FETCH_ADDR_TRACE_EN
  logic [XLEN-1:0] r_aq [DEPTH];
  logic [XLEN-1:0] r_amem [DEPTH];
  logic [AW-1:0]   r_aq_wr;
  logic [AW-1:0]   r_aq_rd;
  logic [XLEN-1:0] r_inst_addr;
  logic [XLEN-1:0] w_head_addr;

  // Head address follows the same selection as the head word.
  always_comb begin
    if (w_push && (w_rd_nxt == r_wr_ptr)) begin
      w_head_addr = r_aq[r_aq_rd];
    end else begin
      w_head_addr = r_amem[w_rd_nxt];
    end
  end

  // Capture the address at issue; move it beside the data when the word lands.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_aq[r_aq_wr] <= r_pc;
    end
    if (w_push) begin
      r_amem[r_wr_ptr] <= r_aq[r_aq_rd];
    end
  end

  // In-flight address queue pointers (every response retires one entry) and head address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_aq_wr     <= AW'(0);
      r_aq_rd     <= AW'(0);
      r_inst_addr <= XLEN'(0);
    end else begin
      if (w_issue) begin
        r_aq_wr <= r_aq_wr + AW'(1);
      end
      if (w_rsp) begin
        r_aq_rd <= r_aq_rd + AW'(1);
      end
      if (w_head_load) begin
        r_inst_addr <= w_head_addr;
      end
    end
  end

  assign inst_addr_o = r_inst_addr;
`endif

  fetch_queue_unit_chk #(.CW(CW)) u_chk (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_rvalid      (mem_rvalid_i),
    .i_outstanding (r_outstanding)
  );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit. A queue-based model tracks issued
// requests (with a per-request "discard" mark), the buffered words and the PC.
// The DUT outputs are compared against the model every cycle, and directed
// literal checks pin the model to hand-computed values.
module tb_fetch_queue_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        jump_flag_i, mem_gnt_i, mem_rvalid_i, inst_ready_i;
  logic [31:0] jump_addr_i, mem_rdata_i;
  logic        mem_req_o, inst_valid_o;
  logic [31:0] mem_addr_o, inst_o;
  logic        gnt2, req2, valid2;
  logic [31:0] addr2, inst2;
`ifdef FETCH_ADDR_TRACE_EN
  logic [31:0] inst_addr_o, iaddr2;
`endif

  always #5 clk = ~clk;

  fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .inst_o(inst_o)
`ifdef FETCH_ADDR_TRACE_EN
    , .inst_addr_o(inst_addr_o)
`endif
  );

  fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_wrap (
    .clk(clk), .reset_n(reset_n), .jump_flag_i(1'b0), .jump_addr_i(32'h0),
    .mem_req_o(req2), .mem_addr_o(addr2), .mem_gnt_i(gnt2),
    .mem_rvalid_i(1'b0), .mem_rdata_i(32'h0), .inst_valid_o(valid2),
    .inst_ready_i(1'b0), .inst_o(inst2)
`ifdef FETCH_ADDR_TRACE_EN
    , .inst_addr_o(iaddr2)
`endif
  );

  typedef struct { logic [31:0] addr; bit drop; } inf_t;
  inf_t        inf_q[$];
  logic [31:0] fifo_d[$];
  logic [31:0] fifo_a[$];
  logic [31:0] m_pc, exp_inst, exp_iaddr;
  int          errors = 0;
  int          checks = 0;
  int          grants = 0;
  logic [31:0] wrap_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    inf_q.delete();
    fifo_d.delete();
    fifo_a.delete();
    m_pc      = 32'h0;
    exp_inst  = 32'h0;
    exp_iaddr = 32'h0;
  endtask

  // Apply one cycle of inputs, let them settle, compare DUT against the model.
  task automatic drive(input bit j, input logic [31:0] ja, input bit g, input bit rv, input bit rdy);
    bit exp_req;
    jump_flag_i  = j;
    jump_addr_i  = ja;
    mem_gnt_i    = g;
    mem_rvalid_i = rv && (inf_q.size() > 0);
    mem_rdata_i  = (inf_q.size() > 0) ? word_of(inf_q[0].addr) : 32'h0;
    inst_ready_i = rdy;
    #1;
    exp_req = reset_n && ((inf_q.size() + fifo_d.size()) < DEPTH) && !j;
    chk("mem_req", 32'(mem_req_o), 32'(exp_req));
    chk("mem_addr", mem_addr_o, m_pc);
    chk("inst_valid", 32'(inst_valid_o), 32'(fifo_d.size() != 0));
    chk("inst", inst_o, exp_inst);
`ifdef FETCH_ADDR_TRACE_EN
    chk("inst_addr", inst_addr_o, exp_iaddr);
`endif
  endtask

  // Clock edge: advance the model with the inputs applied this cycle.
  task automatic tick();
    bit   req;
    inf_t e;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      req = ((inf_q.size() + fifo_d.size()) < DEPTH) && !jump_flag_i;
      if (fifo_d.size() > 0 && inst_ready_i) begin
        void'(fifo_d.pop_front());
        void'(fifo_a.pop_front());
      end
      if (mem_rvalid_i && inf_q.size() > 0) begin
        e = inf_q.pop_front();
        if (!jump_flag_i && !e.drop) begin
          fifo_d.push_back(word_of(e.addr));
          fifo_a.push_back(e.addr);
        end
      end
      if (jump_flag_i) begin
        fifo_d.delete();
        fifo_a.delete();
        foreach (inf_q[i]) inf_q[i].drop = 1'b1;
        m_pc = jump_addr_i;
      end else if (req && mem_gnt_i) begin
        inf_q.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
        grants++;
      end
      if (fifo_d.size() > 0) begin
        exp_inst  = fifo_d[0];
        exp_iaddr = fifo_a[0];
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input bit j, input logic [31:0] ja, input bit g, input bit rv, input bit rdy);
    drive(j, ja, g, rv, rdy);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; jump_flag_i = 1'b0; jump_addr_i = 32'h0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; inst_ready_i = 1'b0; gnt2 = 1'b0;
    model_reset();
    #1;
    chk("rst_req", 32'(mem_req_o), 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_valid", 32'(inst_valid_o), 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming: one grant per cycle, response one cycle later, decode always ready.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      chk("lit_stream_addr", mem_addr_o, 32'(4 * k));
      if (k >= 2) begin
        chk("lit_stream_valid", 32'(inst_valid_o), 32'h1);
        chk("lit_stream_inst", inst_o, word_of(32'(4 * (k - 2))));
      end
      tick();
    end
    drain();

    // Backpressure: decode stalled, credit stops issue after DEPTH grants.
    grants = 0;
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("lit_bp_grants", 32'(grants), 32'd4);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("lit_bp_req", 32'(mem_req_o), 32'h0);
    chk("lit_bp_head", inst_o, 32'hDEAD_0020);
    tick();
    grants = 0;
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("lit_bp_one_more", 32'(grants), 32'd1);
    drain();

    // Jump with three requests in flight and one word buffered.
    step(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    chk("lit_jmp_head_before", inst_o, 32'hDEAD_000C);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (k == 0) chk("lit_jmp_flushed", 32'(inst_valid_o), 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_jmp_first_kept", inst_o, 32'hDEAD_0100);
    chk("lit_jmp_valid", 32'(inst_valid_o), 32'h1);
    tick();
    drain();

    // Jump + response + pop in the same cycle with two outstanding.
    step(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0300, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("lit_sim_empty", 32'(inst_valid_o), 32'h0);
    chk("lit_sim_hold", inst_o, 32'hDEAD_0200);
    tick();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_sim_kept", inst_o, 32'hDEAD_0300);
    tick();
    drain();

    // Back-to-back jumps: second target wins, old responses are dropped.
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0500, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_b2b_kept", inst_o, 32'hDEAD_0500);
    tick();
    drain();

    // PC wrap on the second instance (RESET_PC = FFFF_FFF8).
    gnt2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("lit_wrap_req", 32'(req2), 32'h1);
      chk("lit_wrap_addr", addr2, wrap_exp[k]);
      tick();
    end
    gnt2 = 1'b0;
    chk("lit_wrap_valid", 32'(valid2), 32'h0);
    chk("lit_wrap_inst", inst2, 32'h0);

    // Asynchronous reset between edges with two requests outstanding.
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("lit_arst_req", 32'(mem_req_o), 32'h0);
    chk("lit_arst_valid", 32'(inst_valid_o), 32'h0);
    chk("lit_arst_inst", inst_o, 32'h0);
    chk("lit_arst_addr", mem_addr_o, 32'h0);
    model_reset();
    tick();
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("lit_post_rst_req", 32'(mem_req_o), 32'h1);
    chk("lit_post_rst_addr", mem_addr_o, 32'h0);
    tick();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_post_rst_inst", inst_o, 32'hDEAD_0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
